// File: rtl/onchip_ram_pkg.sv
// Shared types and default sizes for the on-chip RAM arbiter slice.
package onchip_ram_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef logic master_id_t;

  // Read-return tag: one per in-flight read, tracks who asked for it.
  typedef struct packed {
    logic       valid;
    master_id_t owner;
  } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a last-grant register.
// Generic enough to front any single-port shared slave.
module rr_arb2
  import onchip_ram_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output master_id_t winner
);

  master_id_t last_grant;

  // On a tie the requester that did not win last time goes; otherwise pass req through.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (last_grant == 1'b1) ? 2'b01 : 2'b10;
  end

  // Master 0 when nobody is granted, so downstream muxes default to master 0.
  assign winner = master_id_t'(gnt[1]);

  // Remember the winner; reset to 1 so master 0 takes the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   last_grant <= 1'b1;
    else if (|gnt)  last_grant <= winner;
  end

endmodule

// File: rtl/onchip_ram_arbiter.sv
// Round-robin sharing of one single-port RAM between two Avalon-MM masters.
// One access per cycle; read data is steered back by a latency-matched tag pipe.
module onchip_ram_arbiter #(
  parameter int ADDR_W     = onchip_ram_pkg::ADDR_W,
  parameter int DATA_W     = onchip_ram_pkg::DATA_W,
  parameter int BE_W       = onchip_ram_pkg::BE_W,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  output logic              ram_reset_req,
  input  logic [DATA_W-1:0] ram_readdata
);
  import onchip_ram_pkg::master_id_t;
  import onchip_ram_pkg::rd_tag_t;

  localparam int NM = 2;

  logic [NM-1:0][ADDR_W-1:0] m_addr;
  logic [NM-1:0][BE_W-1:0]   m_be;
  logic [NM-1:0][DATA_W-1:0] m_wdata;
  logic [NM-1:0]             m_rd, m_wr;
  logic [NM-1:0]             req, gnt, rdv;
  master_id_t                winner;
  logic                      any_gnt, rd_issue;

  rd_tag_t [RD_LATENCY-1:0]  tag_pipe;
  rd_tag_t                   tag_out;

  assign m_addr  = {m1_address, m0_address};
  assign m_be    = {m1_byteenable, m0_byteenable};
  assign m_wdata = {m1_writedata, m0_writedata};
  assign m_rd    = {m1_read, m0_read};
  assign m_wr    = {m1_write, m0_write};

  // A read with write also asserted counts as a write.
  assign req = m_rd | m_wr;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt),
    .winner  (winner)
  );

  assign any_gnt  = |gnt;
  assign rd_issue = any_gnt & m_rd[winner] & ~m_wr[winner];

  // Winner mux; with no grant winner is 0 and chipselect stays low.
  assign ram_address    = m_addr[winner];
  assign ram_byteenable = m_be[winner];
  assign ram_writedata  = m_wdata[winner];
  assign ram_write      = any_gnt & m_wr[winner];
  assign ram_chipselect = any_gnt;

  assign ram_clken     = reset_n;
  assign ram_reset_req = ~reset_n;

  // Owner tag pipe: free-running, matches RAM read latency, cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= '{valid: rd_issue, owner: winner};
      for (int i = 1; i < RD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_out = tag_pipe[RD_LATENCY-1];

  for (genvar g = 0; g < NM; g++) begin : g_ret
    assign rdv[g] = tag_out.valid & (tag_out.owner == 1'(g));
  end

  assign m0_waitrequest   = req[0] & ~gnt[0];
  assign m1_waitrequest   = req[1] & ~gnt[1];
  assign m0_readdatavalid = rdv[0];
  assign m1_readdatavalid = rdv[1];
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;

endmodule
